bcd_mult_seq: RTL and testbench

Sequential, parametrised BCD multiplier. It replaces the combinational convert–array-multiply–convert chain with a single shift-based datapath. The block accepts two DIGITS-digit packed-BCD operands on a start pulse and converts them to binary. It then multiplies by shift-add and converts the product back to packed BCD by double-dabble, one bit per clock. The result feeds the board's seven-segment decoders, one instance per 4-bit result nibble, which sit outside this block.

---
 rtl/bcd_mult_seq_pkg.sv | 23 ++
 rtl/bcd_mult_seq_if.sv | 16 +
 rtl/bcd_mult_seq_dabble_step.sv | 17 +
 rtl/bcd_mult_seq.sv | 143 ++++++++++++++
 tb/tb_bcd_mult_seq.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/bcd_mult_seq_pkg.sv
// Shared definitions for the sequential BCD multiplier: FSM encoding,
// operand-width helper and the largest legal BCD digit.
package bcd_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CONV = 3'd1,
    S_MUL  = 3'd2,
    S_DBL  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [3:0] BCD_NIBBLE_MAX = 4'd9;

  // Binary width needed to hold any DIGITS-digit decimal value.
  function automatic int bin_width(input int digits);
    int p;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    return $clog2(p);
  endfunction

endpackage

// File: rtl/bcd_mult_seq_if.sv
// Request/result bundle of the BCD multiplier; the master issues start with
// operands, the slave answers with busy/done/err/result.
interface bcd_mult_seq_if #(parameter int DIGITS = 2);

  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [8*DIGITS-1:0]   result;

  modport master (output start, a, b, input busy, done, err, result);
  modport slave  (input start, a, b, output busy, done, err, result);

endinterface

// File: rtl/bcd_mult_seq_dabble_step.sv
// Double-dabble correction: add 3 to every BCD nibble that is 5 or more,
// combinational, no handshake.
module bcd_dabble_step #(
  parameter int N = 4
) (
  input  logic [4*N-1:0] din,
  output logic [4*N-1:0] dout
);

  always_comb begin
    dout = din;
    for (int i = 0; i < N; i++) begin
      if (din[4*i +: 4] >= 4'd5) dout[4*i +: 4] = din[4*i +: 4] + 4'd3;
    end
  end

endmodule

// File: rtl/bcd_mult_seq.sv
// Sequential BCD multiplier: BCD->binary, shift-add multiply, double-dabble back.
// done follows start by DIGITS+BW+PW edges; start is ignored unless idle.
module bcd_mult_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input logic           clk,
  input logic           rst,
  bcd_mult_seq_if.slave bus
);

  localparam int BW = bin_width(DIGITS);
  localparam int PW = 2 * BW;
  localparam int OW = 4 * DIGITS;
  localparam int RW = 8 * DIGITS;
  localparam int CW = $clog2(PW);

  state_t          state;
  logic [OW-1:0]   a_q, b_q;
  logic [BW-1:0]   abin, bbin;
  logic [PW-1:0]   acc;
  logic [RW-1:0]   bcd;
  logic [CW-1:0]   cnt;
  logic            busy_q, done_q, err_q;
  logic [RW-1:0]   result_q;

  logic            bad_in;
  logic [RW-1:0]   bcd_fix;
  logic [RW-1:0]   bcd_next;
  logic [PW-1:0]   mcand;

  function automatic logic [BW-1:0] mul10_add(input logic [BW-1:0] v, input logic [3:0] d);
    logic [BW-1:0] dz;
    dz      = '0;
    dz[3:0] = d;
    return (v << 3) + (v << 1) + dz;
  endfunction

  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.a[4*i +: 4] > BCD_NIBBLE_MAX || bus.b[4*i +: 4] > BCD_NIBBLE_MAX) bad_in = 1'b1;
    end
  end

  bcd_dabble_step #(.N(2 * DIGITS)) u_dabble (
    .din  (bcd),
    .dout (bcd_fix)
  );

  assign bcd_next = {bcd_fix[RW-2:0], acc[PW-1]};
  assign mcand    = {{BW{1'b0}}, abin};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      abin     <= '0;
      bbin     <= '0;
      acc      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_q  <= bus.a;
            b_q  <= bus.b;
            abin <= '0;
            bbin <= '0;
            acc  <= '0;
            bcd  <= '0;
            cnt  <= '0;
            if (bad_in) begin
              // Illegal digit: skip the datapath and report immediately.
              state    <= S_DONE;
              done_q   <= 1'b1;
              err_q    <= 1'b1;
              result_q <= '0;
            end else begin
              state  <= S_CONV;
              busy_q <= 1'b1;
            end
          end
        end
        S_CONV: begin
          abin <= mul10_add(abin, a_q[OW-1 -: 4]);
          bbin <= mul10_add(bbin, b_q[OW-1 -: 4]);
          a_q  <= a_q << 4;
          b_q  <= b_q << 4;
          if (cnt == CW'(DIGITS - 1)) begin
            cnt   <= '0;
            state <= S_MUL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_MUL: begin
          // bbin shifts right so that bit cnt of the multiplier sits at bit 0.
          if (bbin[0]) acc <= acc + (mcand << cnt);
          bbin <= bbin >> 1;
          if (cnt == CW'(BW - 1)) begin
            cnt   <= '0;
            state <= S_DBL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DBL: begin
          bcd <= bcd_next;
          acc <= acc << 1;
          if (cnt == CW'(PW - 1)) begin
            cnt      <= '0;
            state    <= S_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            err_q    <= 1'b0;
            result_q <= bcd_next;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_bcd_mult_seq.sv
// Bench for bcd_mult_seq: directed cases on a 2-digit instance, then a
// randomized sweep on a 3-digit instance against a decimal reference model.
module tb_bcd_mult_seq;

  logic clk;
  logic rst2, rst3;
  int   npass, ntot;

  bcd_mult_seq_if #(.DIGITS(2)) b2 ();
  bcd_mult_seq_if #(.DIGITS(3)) b3 ();

  bcd_mult_seq #(.DIGITS(2)) dut2 (.clk(clk), .rst(rst2), .bus(b2));
  bcd_mult_seq #(.DIGITS(3)) dut3 (.clk(clk), .rst(rst3), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint bcd2int(input logic [63:0] v, input int nd);
    longint r;
    r = 0;
    for (int i = nd - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [63:0] int2bcd(input longint x, input int nd);
    logic [63:0] r;
    longint      t;
    r = '0;
    t = x;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [63:0] ref_mult(input logic [63:0] av, input logic [63:0] bv, input int nd);
    return int2bcd(bcd2int(av, nd) * bcd2int(bv, nd), 2 * nd);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic start2(input logic [7:0] av, input logic [7:0] bv);
    b2.start = 1'b1;
    b2.a     = av;
    b2.b     = bv;
    tick();
    b2.start = 1'b0;
    b2.a     = 8'($urandom);
    b2.b     = 8'($urandom);
  endtask

  task automatic start3(input logic [11:0] av, input logic [11:0] bv);
    b3.start = 1'b1;
    b3.a     = av;
    b3.b     = bv;
    tick();
    b3.start = 1'b0;
    b3.a     = 12'($urandom);
    b3.b     = 12'($urandom);
  endtask

  task automatic wait2(input int n0, output int n);
    n = n0;
    while (b2.done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic wait3(output int n);
    n = 0;
    while (b3.done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int          n;
    int          x, y;
    logic        saw_done;
    logic [63:0] ea, eb;

    npass = 0;
    ntot  = 0;
    b2.start = 1'b0; b2.a = '0; b2.b = '0;
    b3.start = 1'b0; b3.a = '0; b3.b = '0;
    rst2 = 1'b1;
    rst3 = 1'b1;
    tick();
    tick();
    rst2 = 1'b0;
    rst3 = 1'b0;

    chk("rst_busy", 64'(b2.busy), 64'(0));
    chk("rst_done", 64'(b2.done), 64'(0));
    chk("rst_err", 64'(b2.err), 64'(0));
    chk("rst_result", 64'(b2.result), 64'(0));
    chk("rst3_result", 64'(b3.result), 64'(0));

    // 12 x 34
    start2(8'h12, 8'h34);
    chk("t1_busy", 64'(b2.busy), 64'(1));
    wait2(0, n);
    chk("t1_latency", 64'(n), 64'(23));
    chk("t1_result", 64'(b2.result), ref_mult(64'h12, 64'h34, 2));
    chk("t1_err", 64'(b2.err), 64'(0));
    chk("t1_busy_at_done", 64'(b2.busy), 64'(0));
    tick();
    chk("t1_done_pulse", 64'(b2.done), 64'(0));

    // 99 x 99, then 00 x 57 with result held mid-operation
    start2(8'h99, 8'h99);
    wait2(0, n);
    chk("t2a_latency", 64'(n), 64'(23));
    chk("t2a_result", 64'(b2.result), ref_mult(64'h99, 64'h99, 2));
    tick();
    start2(8'h00, 8'h57);
    tick();
    chk("t2b_hold", 64'(b2.result), ref_mult(64'h99, 64'h99, 2));
    wait2(1, n);
    chk("t2b_latency", 64'(n), 64'(23));
    chk("t2b_result", 64'(b2.result), 64'(0));
    tick();

    // Illegal digit
    start2(8'h1A, 8'h05);
    chk("t3_done", 64'(b2.done), 64'(1));
    chk("t3_err", 64'(b2.err), 64'(1));
    chk("t3_result", 64'(b2.result), 64'(0));
    chk("t3_busy", 64'(b2.busy), 64'(0));
    tick();
    start2(8'h07, 8'h03);
    wait2(0, n);
    chk("t3_clear_err", 64'(b2.err), 64'(0));
    chk("t3_next_result", 64'(b2.result), ref_mult(64'h07, 64'h03, 2));
    tick();

    // start during busy is dropped; start held through DONE restarts once idle
    start2(8'h12, 8'h34);
    for (int i = 1; i < 5; i++) tick();
    b2.start = 1'b1; b2.a = 8'h99; b2.b = 8'h99;
    tick();
    b2.start = 1'b0;
    wait2(5, n);
    chk("t4_latency", 64'(n), 64'(23));
    chk("t4_result", 64'(b2.result), ref_mult(64'h12, 64'h34, 2));
    b2.start = 1'b1; b2.a = 8'h99; b2.b = 8'h99;
    tick();
    chk("t4_idle_gap", 64'(b2.busy), 64'(0));
    tick();
    chk("t4_restart_busy", 64'(b2.busy), 64'(1));
    b2.start = 1'b0;
    wait2(0, n);
    chk("t4_restart_latency", 64'(n), 64'(23));
    chk("t4_restart_result", 64'(b2.result), ref_mult(64'h99, 64'h99, 2));
    tick();

    // Reset mid-operation
    start2(8'h12, 8'h34);
    for (int i = 1; i < 10; i++) tick();
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    chk("t5_busy", 64'(b2.busy), 64'(0));
    chk("t5_result", 64'(b2.result), 64'(0));
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (b2.done === 1'b1) saw_done = 1'b1;
      tick();
    end
    chk("t5_no_done", 64'(saw_done), 64'(0));
    start2(8'h07, 8'h08);
    wait2(0, n);
    chk("t5_latency", 64'(n), 64'(23));
    chk("t5_result", 64'(b2.result), 64'h0056);
    tick();

    // Three-digit instance
    start3(12'h999, 12'h999);
    wait3(n);
    chk("t6_latency", 64'(n), 64'(33));
    chk("t6_result", 64'(b3.result), 64'h998001);
    tick();

    for (int k = 0; k < 1000; k++) begin
      x  = int'($urandom_range(0, 999));
      y  = int'($urandom_range(0, 999));
      ea = int2bcd(longint'(x), 3);
      eb = int2bcd(longint'(y), 3);
      start3(ea[11:0], eb[11:0]);
      wait3(n);
      chk("rnd_latency", 64'(n), 64'(33));
      chk("rnd_result", 64'(b3.result), int2bcd(longint'(x) * longint'(y), 6));
      tick();
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
